// File: rtl/watch_pkg.sv
// Shared types, limits and helpers for the watch time-setting controller:
// edit FSM state encoding, field maxima, blank digit and BCD split.
package watch_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_HOURS = 3'd1,
        ST_MIN   = 3'd2,
        ST_SEC   = 3'd3
    } state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Digit format is {enable, bcd[3:0], dp}; blank is disabled, dp on.
    localparam logic [5:0] BLANK_DIGIT = 6'b0_0000_1;

    // Split a binary value (0..63) into {tens, units}.
    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 6'd10);
        u = 4'(v % 6'd10);
        return {t, u};
    endfunction

    // Out-of-range values land on 0 going up and on the max going down.
    function automatic logic [5:0] fld_inc(input logic [5:0] v,
                                           input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] fld_dec(input logic [5:0] v,
                                           input logic [5:0] max);
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button press edge detect with optional hold-to-repeat step generator.
// Ports: clk_i, rst_i, btn_i (debounced level), clear_i (kill timer and
// step this cycle), press_o (rising edge), step_o (one-cycle step pulse).
module btn_repeat #(
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned DELAY_CYCLES  = 8,
    parameter int unsigned PERIOD_CYCLES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic clear_i,
    output logic press_o,
    output logic step_o
);

    logic        prev_q;
    logic        rep_q, rep_d;
    logic [31:0] cnt_q, cnt_d;
    logic        hit;

    // cnt_q counts held cycles since the press (or since the last repeat
    // step); rep_q selects the initial delay or the repeat period.
    always_comb begin
        press_o = btn_i & ~prev_q;
        hit     = 1'b0;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        if (!btn_i || clear_i || !REPEAT_EN) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (press_o) begin
            cnt_d = 32'd1;
            rep_d = 1'b0;
        end else if (!rep_q && cnt_q == DELAY_CYCLES) begin
            hit   = 1'b1;
            cnt_d = 32'd1;
            rep_d = 1'b1;
        end else if (rep_q && cnt_q == PERIOD_CYCLES) begin
            hit   = 1'b1;
            cnt_d = 32'd1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        step_o = (press_o | hit) & ~clear_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            rep_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn_i;
            rep_q  <= rep_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_setter.sv
// HH:MM:SS time-setting controller: RUN -> hours -> minutes -> seconds edit
// cycle with auto-repeat, idle abort, commit strobe and blinking display.
// Ports: clk_100MHz_i, reset_i; seconds_i/minutes_i/hours_i from the
// counter; btn_config_i/btn_inc_i/btn_dec_i debounced levels;
// count_enable_o, load_*_o, load_time_o to the counter; d1..d8 digits
// {enable, bcd[3:0], dp} to the display driver.
module watch_setter
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ               = 100_000_000,
    parameter int unsigned BLINK_HALF_CYCLES    = CLK_HZ / 2,
    parameter int unsigned REPEAT_DELAY_CYCLES  = CLK_HZ / 2,
    parameter int unsigned REPEAT_PERIOD_CYCLES = CLK_HZ / 10,
    parameter int unsigned TIMEOUT_CYCLES       = 10 * CLK_HZ,
    parameter int unsigned HOUR_MAX             = 23,
    parameter bit          SHOW_12H             = 1'b0
) (
    input  logic       clk_100MHz_i,
    input  logic       reset_i,
    input  logic [5:0] seconds_i,
    input  logic [5:0] minutes_i,
    input  logic [4:0] hours_i,
    input  logic       btn_config_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    output logic       count_enable_o,
    output logic [5:0] load_seconds_o,
    output logic [5:0] load_minutes_o,
    output logic [4:0] load_hours_o,
    output logic       load_time_o,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8
);

    state_t      state_q, state_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [4:0]  hr_q, hr_d;
    logic        load_q, load_d;
    logic        blink_q, blink_d;
    logic [31:0] bcnt_q, bcnt_d;
    logic [31:0] idle_q, idle_d;

    logic cfg_press, cfg_step;
    logic inc_press, inc_step;
    logic dec_press, dec_step;
    logic both, editing, inc_s, dec_s;
    logic act, timeout, enter;

    assign both = btn_inc_i & btn_dec_i;

    btn_repeat #(
        .REPEAT_EN     (1'b0),
        .DELAY_CYCLES  (1),
        .PERIOD_CYCLES (1)
    ) u_cfg (
        .clk_i   (clk_100MHz_i),
        .rst_i   (reset_i),
        .btn_i   (btn_config_i),
        .clear_i (1'b0),
        .press_o (cfg_press),
        .step_o  (cfg_step)
    );

    btn_repeat #(
        .REPEAT_EN     (1'b1),
        .DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_inc (
        .clk_i   (clk_100MHz_i),
        .rst_i   (reset_i),
        .btn_i   (btn_inc_i),
        .clear_i (both),
        .press_o (inc_press),
        .step_o  (inc_step)
    );

    btn_repeat #(
        .REPEAT_EN     (1'b1),
        .DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_dec (
        .clk_i   (clk_100MHz_i),
        .rst_i   (reset_i),
        .btn_i   (btn_dec_i),
        .clear_i (both),
        .press_o (dec_press),
        .step_o  (dec_step)
    );

    always_comb begin
        editing = state_q inside {ST_HOURS, ST_MIN, ST_SEC};
        // A config press in the same cycle swallows the step.
        inc_s   = inc_step & ~cfg_step & editing;
        dec_s   = dec_step & ~cfg_step & editing;
        act     = cfg_press | cfg_step | inc_press | dec_press
                | inc_step | dec_step;
        timeout = editing & ~act & (idle_q == TIMEOUT_CYCLES - 1);

        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        load_d  = 1'b0;
        enter   = 1'b0;
        idle_d  = (editing && !act) ? idle_q + 32'd1 : 32'd0;

        case (state_q)
            ST_RUN: begin
                sec_d = seconds_i;
                min_d = minutes_i;
                hr_d  = hours_i;
                if (cfg_step) begin
                    state_d = ST_HOURS;
                    enter   = 1'b1;
                end
            end
            ST_HOURS: begin
                if (cfg_step) begin
                    state_d = ST_MIN;
                    enter   = 1'b1;
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else if (inc_s) begin
                    hr_d = 5'(fld_inc({1'b0, hr_q}, 6'(HOUR_MAX)));
                end else if (dec_s) begin
                    hr_d = 5'(fld_dec({1'b0, hr_q}, 6'(HOUR_MAX)));
                end
            end
            ST_MIN: begin
                if (cfg_step) begin
                    state_d = ST_SEC;
                    enter   = 1'b1;
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else if (inc_s) begin
                    min_d = fld_inc(min_q, MIN_MAX);
                end else if (dec_s) begin
                    min_d = fld_dec(min_q, MIN_MAX);
                end
            end
            ST_SEC: begin
                if (cfg_step) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else if (inc_s) begin
                    sec_d = fld_inc(sec_q, SEC_MAX);
                end else if (dec_s) begin
                    sec_d = fld_dec(sec_q, SEC_MAX);
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (enter) idle_d = '0;

        // Feedback: any edit activity shows the field solidly for a phase.
        blink_d = blink_q;
        if (enter || inc_s || dec_s) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_HALF_CYCLES - 1) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d  = bcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            idle_q  <= idle_d;
        end
    end

    assign count_enable_o = (state_q == ST_RUN);
    assign load_seconds_o = sec_q;
    assign load_minutes_o = min_q;
    assign load_hours_o   = hr_q;
    assign load_time_o    = load_q;

    logic       run;
    logic [4:0] hr_src, hr_disp;
    logic [7:0] hb, mb, sb;
    logic       en_h, en_m, en_s;

    always_comb begin
        run     = (state_q == ST_RUN);
        hr_src  = run ? hours_i : hr_q;
        hr_disp = hr_src;
        if (SHOW_12H) begin
            if (hr_src == 5'd0)       hr_disp = 5'd12;
            else if (hr_src > 5'd12)  hr_disp = hr_src - 5'd12;
        end
        hb   = bcd_split({1'b0, hr_disp});
        mb   = bcd_split(run ? minutes_i : min_q);
        sb   = bcd_split(run ? seconds_i : sec_q);
        en_h = (state_q == ST_HOURS) ? blink_q : 1'b1;
        en_m = (state_q == ST_MIN)   ? blink_q : 1'b1;
        en_s = (state_q == ST_SEC)   ? blink_q : 1'b1;
    end

    assign d8 = {en_h, hb[7:4], 1'b1};
    assign d7 = {en_h, hb[3:0], 1'b1};
    assign d6 = BLANK_DIGIT;
    assign d5 = {en_m, mb[7:4], 1'b1};
    assign d4 = {en_m, mb[3:0], 1'b1};
    assign d3 = BLANK_DIGIT;
    assign d2 = {en_s, sb[7:4], 1'b1};
    assign d1 = {en_s, sb[3:0], 1'b1};

endmodule

// File: tb/tb_watch_setter.sv
// Bench for watch_setter: directed edit scenarios plus random buttons,
// all checked each cycle against a behavioural model of the setter.
module tb_watch_setter;

    localparam int H  = 4;
    localparam int D  = 8;
    localparam int P  = 3;
    localparam int TO = 40;
    localparam int HM = 23;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec_i, min_i;
    logic [4:0] hr_i;
    logic       bcfg, binc, bdec;

    logic       ce, lt;
    logic [5:0] ls, lm;
    logic [4:0] lh;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;

    logic       ce2, lt2;
    logic [5:0] ls2, lm2;
    logic [4:0] lh2;
    logic [5:0] e1, e2, e3, e4, e5, e6, e7, e8;

    always #5 clk = ~clk;

    watch_setter #(
        .BLINK_HALF_CYCLES(H), .REPEAT_DELAY_CYCLES(D),
        .REPEAT_PERIOD_CYCLES(P), .TIMEOUT_CYCLES(TO),
        .HOUR_MAX(HM), .SHOW_12H(1'b0)
    ) dut (
        .clk_100MHz_i(clk), .reset_i(rst),
        .seconds_i(sec_i), .minutes_i(min_i), .hours_i(hr_i),
        .btn_config_i(bcfg), .btn_inc_i(binc), .btn_dec_i(bdec),
        .count_enable_o(ce), .load_seconds_o(ls),
        .load_minutes_o(lm), .load_hours_o(lh), .load_time_o(lt),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    watch_setter #(
        .BLINK_HALF_CYCLES(H), .REPEAT_DELAY_CYCLES(D),
        .REPEAT_PERIOD_CYCLES(P), .TIMEOUT_CYCLES(TO),
        .HOUR_MAX(HM), .SHOW_12H(1'b1)
    ) dut12 (
        .clk_100MHz_i(clk), .reset_i(rst),
        .seconds_i(sec_i), .minutes_i(min_i), .hours_i(hr_i),
        .btn_config_i(bcfg), .btn_inc_i(binc), .btn_dec_i(bdec),
        .count_enable_o(ce2), .load_seconds_o(ls2),
        .load_minutes_o(lm2), .load_hours_o(lh2), .load_time_o(lt2),
        .d1(e1), .d2(e2), .d3(e3), .d4(e4),
        .d5(e5), .d6(e6), .d7(e7), .d8(e8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model: mode 0=run 1=hours 2=minutes 3=seconds.
    int mode, fh, fm, fs;
    bit pc, pi, pd;
    int ti, td, idle;
    bit mload;
    bit bbase;
    int bs;

    int n_load;
    logic [16:0] cap;
    logic cap_ce;

    task automatic model_reset();
        mode = 0; fh = 0; fm = 0; fs = 0;
        pc = 0; pi = 0; pd = 0;
        ti = 0; td = 0; idle = 0;
        mload = 0; bbase = 0; bs = 0;
    endtask

    function automatic int stepv(int v, int mx, bit up);
        if (up) return (v >= mx) ? 0 : v + 1;
        return (v == 0 || v > mx) ? mx : v - 1;
    endfunction

    // A held button steps at hold age 0 (press), D, D+P, D+2P, ...
    function automatic bit held_step(bit lvl, bit pr, int age);
        if (!lvl) return 0;
        if (pr) return 1;
        return age >= D && ((age - D) % P) == 0;
    endfunction

    task automatic model_update();
        bit cp, ip, dp, both, ist, dst, up, dn, act, enter;
        int m0;
        cp   = bcfg && !pc;
        ip   = binc && !pi;
        dp   = bdec && !pd;
        both = binc && bdec;
        ist  = !both && held_step(binc, ip, ti);
        dst  = !both && held_step(bdec, dp, td);
        ti   = (binc && !both) ? ti + 1 : 0;
        td   = (bdec && !both) ? td + 1 : 0;
        pc = bcfg; pi = binc; pd = bdec;
        act  = cp || ip || dp || ist || dst;
        m0   = mode;
        up   = ist && !cp && m0 != 0;
        dn   = dst && !cp && m0 != 0;
        enter = 0;
        mload = 0;
        if (m0 == 0) begin
            fh = hr_i; fm = min_i; fs = sec_i;
            if (cp) begin mode = 1; enter = 1; end
        end else if (cp) begin
            mode  = (m0 + 1) % 4;
            mload = (mode == 0);
            enter = (mode != 0);
        end else if (!act && idle + 1 == TO) begin
            mode = 0;
        end else if (up || dn) begin
            case (m0)
                1: fh = stepv(fh, HM, up);
                2: fm = stepv(fm, 59, up);
                default: fs = stepv(fs, 59, up);
            endcase
        end
        idle = (m0 == 0 || act || mode == 0) ? 0 : idle + 1;
        if (enter || up || dn) begin bbase = 1; bs = 0; end
        else bs++;
    endtask

    function automatic logic [5:0] dig(bit e, int v);
        return {e, 4'(v), 1'b1};
    endfunction

    function automatic logic [47:0] exp_disp(bit s12);
        int h, m, s;
        bit bl, eh, em, es;
        h = (mode == 0) ? int'(hr_i)  : fh;
        m = (mode == 0) ? int'(min_i) : fm;
        s = (mode == 0) ? int'(sec_i) : fs;
        if (s12) begin
            if (h == 0) h = 12;
            else if (h > 12) h -= 12;
        end
        bl = bbase ^ (((bs / H) % 2) == 1);
        eh = (mode == 1) ? bl : 1'b1;
        em = (mode == 2) ? bl : 1'b1;
        es = (mode == 3) ? bl : 1'b1;
        return {dig(eh, h / 10), dig(eh, h % 10), 6'b000001,
                dig(em, m / 10), dig(em, m % 10), 6'b000001,
                dig(es, s / 10), dig(es, s % 10)};
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        if (lt) begin
            n_load++;
            cap    = {lh, lm, ls};
            cap_ce = ce;
        end
        chk("count_en", ce, mode == 0);
        chk("load_strobe", lt, mload);
        chk("load_val", {lh, lm, ls}, {5'(fh), 6'(fm), 6'(fs)});
        chk("digits", {d8, d7, d6, d5, d4, d3, d2, d1}, exp_disp(0));
        chk("digits12", {e8, e7, e6, e5, e4, e3, e2, e1}, exp_disp(1));
    endtask

    task automatic press(input bit c, input bit i, input bit d);
        bcfg = c; binc = i; bdec = d;
        tick();
        bcfg = 0; binc = 0; bdec = 0;
        tick();
    endtask

    task automatic set_in(input int h, input int m, input int s);
        hr_i = 5'(h); min_i = 6'(m); sec_i = 6'(s);
    endtask

    int nl;
    int len, r;

    initial begin
        rst = 1'b1;
        bcfg = 0; binc = 0; bdec = 0;
        set_in(9, 41, 27);
        model_reset();
        #12;
        chk("rst_ce", ce, 1);
        chk("rst_lt", lt, 0);
        chk("rst_load", {lh, lm, ls}, 17'd0);
        chk("rst_digits", {d8, d7, d6, d5, d4, d3, d2, d1}, exp_disp(0));
        rst = 1'b0;
        tick();

        // Full edit cycle: 12:34:56 -> 14:33:57
        set_in(12, 34, 56);
        tick();
        n_load = 0;
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        chk("commit_count", n_load, 1);
        chk("commit_val", cap, {5'd14, 6'd33, 6'd57});
        chk("commit_ce", cap_ce, 1);

        // Wraps
        set_in(23, 0, 60);
        tick();
        press(1, 0, 0);
        press(0, 1, 0);
        chk("wrap_hours", lh, 5'd0);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("wrap_min", lm, 6'd59);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("wrap_sec", ls, 6'd0);
        press(1, 0, 0);
        chk("wrap_commit", cap, {5'd0, 6'd59, 6'd0});

        // Hold inc 20 cycles from 10 in minutes
        set_in(5, 10, 0);
        tick();
        press(1, 0, 0);
        press(1, 0, 0);
        binc = 1;
        repeat (20) tick();
        binc = 0;
        tick();
        chk("hold_min", lm, 6'd15);

        bdec = 1; binc = 1;
        repeat (12) tick();
        binc = 0; bdec = 0;
        tick();
        chk("both_min", lm, 6'd15);

        press(1, 1, 0);
        chk("cfgwin_min", lm, 6'd15);
        chk("cfgwin_sec", ls, 6'd0);
        chk("cfgwin_edit", ce, 0);

        // Idle timeout in seconds edit
        nl = n_load;
        repeat (38) tick();
        chk("to_before", ce, 0);
        tick();
        chk("to_after", ce, 1);
        chk("to_noload", n_load, nl);

        // 12-hour display
        set_in(0, 7, 7);
        tick();
        chk("h12_0_d8", e8, 6'b1_0001_1);
        chk("h12_0_d7", e7, 6'b1_0010_1);
        set_in(13, 7, 7);
        tick();
        chk("h12_13_d8", e8, 6'b1_0000_1);
        chk("h12_13_d7", e7, 6'b1_0001_1);
        chk("h12_raw_load", lh2, 5'd13);

        // Reset in the middle of an edit
        set_in(7, 8, 9);
        tick();
        press(1, 0, 0);
        press(0, 1, 0);
        chk("pre_rst_hours", lh, 5'd8);
        nl = n_load;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_ce", ce, 1);
        chk("mid_rst_lt", lt, 0);
        chk("mid_rst_load", {lh, lm, ls}, 17'd0);
        chk("mid_rst_digits", {d8, d7, d6, d5, d4, d3, d2, d1},
            exp_disp(0));
        #1;
        rst = 1'b0;
        tick();
        chk("mid_rst_noload", n_load, nl);

        // Random button traffic
        repeat (120) begin
            len = $urandom_range(1, 30);
            r   = $urandom_range(0, 9);
            bcfg = (r == 0);
            binc = (r inside {[1:4]}) || r == 8;
            bdec = (r inside {[5:7]}) || r == 8;
            if ($urandom_range(0, 3) == 0)
                set_in($urandom_range(0, 31), $urandom_range(0, 63),
                       $urandom_range(0, 63));
            if (bcfg) len = 1;
            repeat (len) tick();
        end
        bcfg = 0; binc = 0; bdec = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
